// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, colour type and window helper for the scan path.
// Defaults describe 640x480@60 Hz from a 50 MHz board clock.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  localparam int CNT_W = 10;
  localparam int DIV_W = 4;

  typedef logic [CNT_W-1:0] count_t;
  typedef logic [2:0]       color_t;

  localparam color_t BLACK = 3'b000;
  localparam color_t WHITE = 3'b111;

  // Half-open window test: start <= c < stop.
  function automatic logic in_window(count_t c, int start, int stop);
    return (c >= count_t'(start)) && (c < count_t'(stop));
  endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Scan bus between the timing controller, the pixel layers and the DAC pins.
// Handshake: pixel_tick is the only strobe; row/col are valid for the whole pixel,
// layers have no ready and must return rgb_in combinationally before the next tick.
interface vga_scan_controller_if;
  import vga_timing_pkg::*;

  count_t row;
  count_t col;
  logic   active;
  logic   pixel_tick;
  logic   frame_start;
  logic   hsync;
  logic   vsync;
  color_t rgb_in;
  color_t rgb;

  modport master (
    output row, col, active, pixel_tick, frame_start, hsync, vsync, rgb,
    input  rgb_in
  );

  modport slave (
    input  row, col, active, pixel_tick, frame_start, hsync, vsync, rgb,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_counter.sv
// Pixel clock-enable divider plus horizontal/vertical scan counters.
// frame_start marks the final pixel edge before the counters return to (0,0).
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_LEN   = H_TOTAL,
  parameter int V_LEN   = V_TOTAL,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic   clk,
  input  logic   rst_n,
  output logic   pixel_tick,
  output count_t h_count,
  output count_t v_count,
  output logic   frame_start
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam count_t H_LAST = count_t'(H_LEN - 1);
  localparam count_t V_LAST = count_t'(V_LEN - 1);

  logic [DIV_W-1:0] div;

  assign pixel_tick  = (div == DIV_LAST);
  assign frame_start = pixel_tick && (h_count == H_LAST) && (v_count == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      div <= pixel_tick ? '0 : div + 1'b1;
      if (pixel_tick) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
          h_count <= h_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA timing source: drives row/col to the pixel layers and registers blanked
// colour plus sync pulses for the DAC, all with one pixel of latency.
module vga_scan_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input logic                   clk,
  input logic                   rst_n,
  vga_scan_controller_if.master vga
);

  localparam int H_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_scan_controller: CLK_DIV must be 1..16");
  end
  if (H_LEN > 1024 || V_LEN > 1024) begin : g_bad_total
    $error("vga_scan_controller: line/frame totals must fit in 10 bits");
  end

  logic   pixel_tick;
  logic   frame_start;
  count_t h_count;
  count_t v_count;
  logic   active;
  logic   hs_win;
  logic   vs_win;
  color_t rgb_q;
  logic   hsync_q;
  logic   vsync_q;

  vga_timing_counter #(
    .H_LEN   (H_LEN),
    .V_LEN   (V_LEN),
    .CLK_DIV (CLK_DIV)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_tick  (pixel_tick),
    .h_count     (h_count),
    .v_count     (v_count),
    .frame_start (frame_start)
  );

  assign active = (h_count < count_t'(H_ACTIVE)) && (v_count < count_t'(V_ACTIVE));
  assign hs_win = in_window(h_count, HS_START, HS_END);
  assign vs_win = in_window(v_count, VS_START, VS_END);

  // rgb_in only passes the mux while active, so blanking-time garbage never lands in rgb_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= BLACK;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else if (pixel_tick) begin
      rgb_q   <= active ? vga.rgb_in : BLACK;
      hsync_q <= hs_win ? SYNC_POL : ~SYNC_POL;
      vsync_q <= vs_win ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.row         = v_count;
  assign vga.col         = h_count;
  assign vga.active      = active;
  assign vga.pixel_tick  = pixel_tick;
  assign vga.frame_start = frame_start;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.rgb         = rgb_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: default build, CLK_DIV=1 build and a shrunken
// timing build whose frames are short enough to observe whole-frame behaviour.
module tb_vga_scan_controller;

  // Shrunken timing: 15 pixels x 13 lines, 3 clk per pixel -> 585 clk per frame.
  localparam int SH_A = 8, SH_FP = 2, SH_S = 3, SH_BP = 2;
  localparam int SV_A = 6, SV_FP = 2, SV_S = 2, SV_BP = 3;
  localparam int SD = 3;

  typedef struct {
    int row; int col; int act; int tick; int fs; int hs; int vs; int pact;
  } exp_t;

  typedef struct {
    int sel; int k; int row; int col; int tick; int hs; int rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   k_a = 0;
  int   k_b = 0;
  bit   run_chk = 1'b0;
  logic [2:0] samp_def = 3'b000;
  logic [2:0] samp_one = 3'b000;
  logic [2:0] samp_sml = 3'b000;

  always #5 clk = ~clk;

  vga_scan_controller_if if_def();
  vga_scan_controller_if if_one();
  vga_scan_controller_if if_sml();

  vga_scan_controller dut_def (.clk(clk), .rst_n(rst_a), .vga(if_def));

  vga_scan_controller #(.CLK_DIV(1)) dut_one (.clk(clk), .rst_n(rst_a), .vga(if_one));

  vga_scan_controller #(
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP),
    .CLK_DIV(SD), .SYNC_POL(1'b0)
  ) dut_sml (.clk(clk), .rst_n(rst_b), .vga(if_sml));

  // Reference: after k clk edges since release, floor(k/d) pixels have elapsed.
  function automatic exp_t model(int k, int d, int ha, int hfp, int hsw, int hbp,
                                 int va, int vfp, int vsw, int vbp);
    exp_t e;
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    int fr = ht * vt;
    int n = k / d;
    int pos = n % fr;
    int prev, ph, pv;
    e.row  = pos / ht;
    e.col  = pos % ht;
    e.act  = (e.col < ha && e.row < va) ? 1 : 0;
    e.tick = (k % d == d - 1) ? 1 : 0;
    e.fs   = (e.tick == 1 && pos == fr - 1) ? 1 : 0;
    if (n == 0) begin
      e.hs = 1; e.vs = 1; e.pact = 0;
    end else begin
      prev = (n - 1) % fr;
      ph = prev % ht;
      pv = prev / ht;
      e.hs = (ph >= ha + hfp && ph < ha + hfp + hsw) ? 0 : 1;
      e.vs = (pv >= va + vfp && pv < va + vfp + vsw) ? 0 : 1;
      e.pact = (ph < ha && pv < va) ? 1 : 0;
    end
    return e;
  endfunction

  function automatic exp_t m_def(int k);
    return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic exp_t m_one(int k);
    return model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic exp_t m_sml(int k);
    return model(k, SD, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP);
  endfunction

  function automatic bit is_tick(int k, int d);
    return (k % d) == d - 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input exp_t e, input logic [2:0] samp,
                         input int row, input int col, input int act, input int tick,
                         input int fs, input int hs, input int vs, input int rgb);
    chk({tag, ".row"}, row, e.row);
    chk({tag, ".col"}, col, e.col);
    chk({tag, ".active"}, act, e.act);
    chk({tag, ".pixel_tick"}, tick, e.tick);
    chk({tag, ".frame_start"}, fs, e.fs);
    chk({tag, ".hsync"}, hs, e.hs);
    chk({tag, ".vsync"}, vs, e.vs);
    chk({tag, ".rgb"}, rgb, (e.pact == 1) ? int'(samp) : 0);
  endtask

  // Elapsed-edge counters and the colour each model expects captured at a pixel edge.
  always @(posedge clk or negedge rst_a)
    if (!rst_a) k_a <= 0; else k_a <= k_a + 1;
  always @(posedge clk or negedge rst_b)
    if (!rst_b) k_b <= 0; else k_b <= k_b + 1;

  always @(posedge clk) begin
    if (rst_a && is_tick(k_a, 2)) samp_def <= if_def.rgb_in;
    if (rst_a && is_tick(k_a, 1)) samp_one <= if_one.rgb_in;
    if (rst_b && is_tick(k_b, SD)) samp_sml <= if_sml.rgb_in;
  end

  always @(negedge clk) begin
    #3 if_sml.rgb_in = 3'($urandom_range(0, 7));
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk_dut("def", m_def(k_a), samp_def, int'(if_def.row), int'(if_def.col),
              int'(if_def.active), int'(if_def.pixel_tick), int'(if_def.frame_start),
              int'(if_def.hsync), int'(if_def.vsync), int'(if_def.rgb));
      chk_dut("one", m_one(k_a), samp_one, int'(if_one.row), int'(if_one.col),
              int'(if_one.active), int'(if_one.pixel_tick), int'(if_one.frame_start),
              int'(if_one.hsync), int'(if_one.vsync), int'(if_one.rgb));
      chk_dut("sml", m_sml(k_b), samp_sml, int'(if_sml.row), int'(if_sml.col),
              int'(if_sml.active), int'(if_sml.pixel_tick), int'(if_sml.frame_start),
              int'(if_sml.hsync), int'(if_sml.vsync), int'(if_sml.rgb));
    end
  end

  initial begin
    #300000;
    bad++;
    total++;
    $display("FAIL watchdog run did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vec_t tbl[15];
    vec_t v;
    int guard, cnt, vs_low, hs_low;
    string nm;

    // Hand-derived waypoints: sel 0 = default build, sel 1 = CLK_DIV=1 build.
    tbl[0]  = '{0, 1,    0, 0,   1, 1, 0};
    tbl[1]  = '{0, 2,    0, 1,   0, 1, 7};
    tbl[2]  = '{1, 656,  0, 656, 1, 1, 0};
    tbl[3]  = '{1, 657,  0, 657, 1, 0, 0};
    tbl[4]  = '{1, 752,  0, 752, 1, 0, 0};
    tbl[5]  = '{1, 753,  0, 753, 1, 1, 0};
    tbl[6]  = '{1, 800,  1, 0,   1, 1, 0};
    tbl[7]  = '{0, 1280, 0, 640, 0, 1, 7};
    tbl[8]  = '{0, 1282, 0, 641, 0, 1, 0};
    tbl[9]  = '{0, 1312, 0, 656, 0, 1, 0};
    tbl[10] = '{0, 1314, 0, 657, 0, 0, 0};
    tbl[11] = '{0, 1504, 0, 752, 0, 0, 0};
    tbl[12] = '{0, 1506, 0, 753, 0, 1, 0};
    tbl[13] = '{0, 1600, 1, 0,   0, 1, 0};
    tbl[14] = '{0, 1602, 1, 1,   0, 1, 7};

    if_def.rgb_in = 3'b111;
    if_one.rgb_in = 3'b111;
    if_sml.rgb_in = 3'b000;
    run_chk = 1'b1;

    repeat (5) @(negedge clk);
    chk("rst.row", int'(if_def.row), 0);
    chk("rst.col", int'(if_def.col), 0);
    chk("rst.active", int'(if_def.active), 1);
    chk("rst.rgb", int'(if_def.rgb), 0);
    chk("rst.hsync", int'(if_def.hsync), 1);
    chk("rst.vsync", int'(if_def.vsync), 1);
    chk("rst.frame_start", int'(if_def.frame_start), 0);
    chk("rst.pixel_tick", int'(if_def.pixel_tick), 0);
    chk("rst.one_tick", int'(if_one.pixel_tick), 1);
    chk("rst.sml_hsync", int'(if_sml.hsync), 1);
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < 15; i++) begin
      v = tbl[i];
      guard = 0;
      while (k_a < v.k && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (k_a != v.k) begin
        total++;
        bad++;
        $display("FAIL tbl_wait[%0d] got=%0d want=%0d", i, k_a, v.k);
      end else if (v.sel == 0) begin
        nm = $sformatf("tbl%0d.def", i);
        chk({nm, ".row"}, int'(if_def.row), v.row);
        chk({nm, ".col"}, int'(if_def.col), v.col);
        chk({nm, ".tick"}, int'(if_def.pixel_tick), v.tick);
        chk({nm, ".hsync"}, int'(if_def.hsync), v.hs);
        chk({nm, ".rgb"}, int'(if_def.rgb), v.rgb);
      end else begin
        nm = $sformatf("tbl%0d.one", i);
        chk({nm, ".row"}, int'(if_one.row), v.row);
        chk({nm, ".col"}, int'(if_one.col), v.col);
        chk({nm, ".tick"}, int'(if_one.pixel_tick), v.tick);
        chk({nm, ".hsync"}, int'(if_one.hsync), v.hs);
        chk({nm, ".rgb"}, int'(if_one.rgb), v.rgb);
      end
    end

    // Mid-frame reset while both syncs are asserted on the pins.
    guard = 0;
    while (!(if_sml.row == 10'd8 && if_sml.col == 10'd11) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst.reached", (if_sml.row == 10'd8 && if_sml.col == 10'd11) ? 1 : 0, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst.row", int'(if_sml.row), 0);
    chk("midrst.col", int'(if_sml.col), 0);
    chk("midrst.active", int'(if_sml.active), 1);
    chk("midrst.hsync", int'(if_sml.hsync), 1);
    chk("midrst.vsync", int'(if_sml.vsync), 1);
    chk("midrst.rgb", int'(if_sml.rgb), 0);
    chk("midrst.frame_start", int'(if_sml.frame_start), 0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    rst_b = 1'b1;

    // First frame_start after release lands one full frame (585 clk) later.
    cnt = 0;
    while (cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (if_sml.frame_start) break;
    end
    chk("frame.first_fs_clk", cnt, 584);

    cnt = 0;
    vs_low = 0;
    hs_low = 0;
    while (cnt < 2000) begin
      @(negedge clk);
      cnt++;
      if (!if_sml.vsync) vs_low++;
      if (!if_sml.hsync) hs_low++;
      if (if_sml.frame_start) break;
    end
    chk("frame.period_clk", cnt, 585);
    chk("frame.vsync_low_clk", vs_low, SV_S * 15 * SD);
    chk("frame.hsync_low_clk", hs_low, 13 * SH_S * SD);

    repeat (600) @(negedge clk);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
